// File: rtl/capture_bank_if.sv
// Signal bundle between the detector/reader side (master) and the capture
// bank controller (slave): capture inputs, RAM write port and bank status.
interface capture_bank_if #(
  parameter int IDX_W  = 8,
  parameter int BANK_W = 1
);
  localparam int NUM_BANKS = 2**BANK_W;

  logic                    signal_detected;
  logic                    sample_valid;
  logic [NUM_BANKS-1:0]    bank_release;

  logic                    we;
  logic [BANK_W+IDX_W-1:0] addr_in;
  logic [BANK_W-1:0]       bank;
  logic [NUM_BANKS-1:0]    bank_full;
  logic [IDX_W-1:0]        idx_final;
  logic [BANK_W-1:0]       done_bank;
  logic                    frame_done;
  logic                    memorization_completed;
  logic                    overflow;
  logic [7:0]              drop_count;
  logic [1:0]              state_reg;

  modport master (
    output signal_detected, sample_valid, bank_release,
    input  we, addr_in, bank, bank_full, idx_final, done_bank,
           frame_done, memorization_completed, overflow, drop_count, state_reg
  );

  modport slave (
    input  signal_detected, sample_valid, bank_release,
    output we, addr_in, bank, bank_full, idx_final, done_bank,
           frame_done, memorization_completed, overflow, drop_count, state_reg
  );
endinterface

// File: rtl/capture_bank_controller.sv
// Round-robin multi-bank capture controller: writes detected samples into
// DEPTH-word banks, rolls over on fill and holds full banks until released.
module capture_bank_controller #(
  parameter int DEPTH  = 200,
  parameter int IDX_W  = 8,
  parameter int BANK_W = 1
) (
  input  logic           clk,
  input  logic           reset,
  capture_bank_if.slave  bus
);
  localparam int NUM_BANKS = 2**BANK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [BANK_W-1:0]    bank_q;
  logic [BANK_W-1:0]    done_bank_q;
  logic [BANK_W-1:0]    nxt;
  logic [NUM_BANKS-1:0] full_q;
  logic [NUM_BANKS-1:0] set_mask;
  logic [IDX_W-1:0]     idx_final_q;
  logic [7:0]           drop_q;
  logic [7:0]           drop_inc;
  logic                 sd_prev;
  logic                 write_now;
  logic                 frame_done_q;
  logic                 mem_done_q;
  logic                 overflow_q;

  assign nxt       = bank_q + BANK_W'(1);
  assign write_now = (state == CAPTURE) && bus.signal_detected && bus.sample_valid;
  assign drop_inc  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  // Bank being closed this cycle; the full flag set takes priority over a release.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    set_mask = '0;
    if (state == CAPTURE) begin
      if (write_now && idx == LAST_IDX)
        set_mask[bank_q] = 1'b1;
      else if (!bus.signal_detected && idx != '0)
        set_mask[bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      bank_q       <= BANK_W'(NUM_BANKS - 1);
      full_q       <= '0;
      idx_final_q  <= '0;
      done_bank_q  <= '0;
      drop_q       <= '0;
      sd_prev      <= 1'b0;
      frame_done_q <= 1'b0;
      mem_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      mem_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
      sd_prev      <= bus.signal_detected;
      full_q       <= (full_q & ~bus.bank_release) | set_mask;

      case (state)
        IDLE: begin
          if (bus.signal_detected) begin
            if (!full_q[nxt]) begin
              bank_q <= nxt;
              idx    <= '0;
              state  <= CAPTURE;
            end else if (!sd_prev) begin
              // Blocked retries while the signal stays high are not recounted.
              overflow_q <= 1'b1;
              drop_q     <= drop_inc;
            end
          end
        end

        CAPTURE: begin
          if (write_now) begin
            if (idx == LAST_IDX) begin
              idx_final_q  <= LAST_IDX;
              done_bank_q  <= bank_q;
              frame_done_q <= 1'b1;
              if (!full_q[nxt]) begin
                bank_q <= nxt;
                idx    <= '0;
              end else begin
                overflow_q <= 1'b1;
                drop_q     <= drop_inc;
                mem_done_q <= 1'b1;
                state      <= DONE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (!bus.signal_detected) begin
            if (idx != '0) begin
              idx_final_q  <= idx - IDX_W'(1);
              done_bank_q  <= bank_q;
              frame_done_q <= 1'b1;
            end
            mem_done_q <= 1'b1;
            state      <= DONE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.we                     = write_now;
  assign bus.addr_in                = {bank_q, idx};
  assign bus.bank                   = bank_q;
  assign bus.bank_full              = full_q;
  assign bus.idx_final              = idx_final_q;
  assign bus.done_bank              = done_bank_q;
  assign bus.frame_done             = frame_done_q;
  assign bus.memorization_completed = mem_done_q;
  assign bus.overflow               = overflow_q;
  assign bus.drop_count             = drop_q;
  assign bus.state_reg              = state;
endmodule

// File: tb/tb_capture_bank_controller.sv
// Scoreboard bench for capture_bank_controller: a per-cycle behavioural model
// queues expected writes/pulses; a negedge monitor pops and compares them.
module tb_capture_bank_controller;
  localparam int DEPTH  = 5;
  localparam int IDX_W  = 3;
  localparam int BANK_W = 2;
  localparam int NB     = 2**BANK_W;

  typedef struct {
    int cyc;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  capture_bank_if #(.IDX_W(IDX_W), .BANK_W(BANK_W)) bus();

  capture_bank_controller #(.DEPTH(DEPTH), .IDX_W(IDX_W), .BANK_W(BANK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t wr_q[$];
  exp_t fr_q[$];
  exp_t ov_q[$];
  exp_t mc_q[$];

  // Reference model: phase 0 idle, 1 capturing, 2 burst finished.
  int            m_phase;
  int            m_bank;
  int            m_count;
  int            m_drops;
  bit            m_prev_sd;
  logic [NB-1:0] m_full;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void push(input int id, input int c, input int d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    case (id)
      0:       wr_q.push_back(e);
      1:       fr_q.push_back(e);
      2:       ov_q.push_back(e);
      default: mc_q.push_back(e);
    endcase
  endfunction

  function automatic bit peek(input int id, output exp_t e);
    e.cyc = 0; e.data = 0;
    case (id)
      0:       begin if (wr_q.size() == 0) return 1'b0; e = wr_q[0]; end
      1:       begin if (fr_q.size() == 0) return 1'b0; e = fr_q[0]; end
      2:       begin if (ov_q.size() == 0) return 1'b0; e = ov_q[0]; end
      default: begin if (mc_q.size() == 0) return 1'b0; e = mc_q[0]; end
    endcase
    return 1'b1;
  endfunction

  function automatic void pop_q(input int id);
    exp_t e;
    case (id)
      0:       e = wr_q.pop_front();
      1:       e = fr_q.pop_front();
      2:       e = ov_q.pop_front();
      default: e = mc_q.pop_front();
    endcase
  endfunction

  task automatic scan(input int id, input logic present, input int actual, input string name);
    exp_t e;
    bit   have;
    have = peek(id, e);
    while (have && e.cyc < cyc) begin
      check({name, " missed"}, 32'd0, 32'd1);
      pop_q(id);
      have = peek(id, e);
    end
    if (present === 1'b1) begin
      if (have && e.cyc == cyc) begin
        check(name, actual, e.data);
        pop_q(id);
      end else begin
        check({name, " unexpected"}, 32'd1, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    scan(0, bus.we, int'(bus.addr_in), "write_addr");
    scan(1, bus.frame_done, int'(bus.done_bank) * 256 + int'(bus.idx_final), "frame_done");
    scan(2, bus.overflow, int'(bus.drop_count), "overflow");
    scan(3, bus.memorization_completed, 0, "mem_completed");
  end

  task automatic model_reset();
    m_phase   = 0;
    m_bank    = NB - 1;
    m_count   = 0;
    m_drops   = 0;
    m_prev_sd = 1'b0;
    m_full    = '0;
  endtask

  task automatic note_drop(input int c);
    if (m_drops < 255) m_drops++;
    push(2, c + 1, m_drops);
  endtask

  task automatic model_step(input bit sd, input bit sv, input logic [NB-1:0] rel, input bit rst);
    logic [NB-1:0] set_m;
    int            nb;
    if (rst) begin
      model_reset();
      return;
    end
    set_m = '0;
    nb    = (m_bank + 1) % NB;
    case (m_phase)
      0: begin
        if (sd) begin
          if (!m_full[nb]) begin
            m_bank = nb; m_count = 0; m_phase = 1;
          end else if (!m_prev_sd) begin
            note_drop(cyc);
          end
        end
      end
      1: begin
        if (sd && sv) begin
          push(0, cyc, m_bank * (1 << IDX_W) + m_count);
          m_count++;
          if (m_count == DEPTH) begin
            set_m[m_bank] = 1'b1;
            push(1, cyc + 1, m_bank * 256 + DEPTH - 1);
            if (!m_full[nb]) begin
              m_bank = nb; m_count = 0;
            end else begin
              note_drop(cyc);
              m_phase = 2;
              push(3, cyc + 1, 0);
            end
          end
        end else if (!sd) begin
          if (m_count > 0) begin
            set_m[m_bank] = 1'b1;
            push(1, cyc + 1, m_bank * 256 + m_count - 1);
          end
          m_phase = 2;
          push(3, cyc + 1, 0);
        end
      end
      default: m_phase = 0;
    endcase
    m_full    = (m_full & ~rel) | set_m;
    m_prev_sd = sd;
  endtask

  // One clock: check registered status against the model, then drive inputs.
  task automatic cycle_step(input bit sd, input bit sv, input logic [NB-1:0] rel, input bit rst);
    @(posedge clk);
    #1;
    check("state_reg", bus.state_reg, m_phase);
    check("bank_full", bus.bank_full, m_full);
    check("drop_count", bus.drop_count, m_drops);
    check("bank", bus.bank, m_bank);
    reset               = rst;
    bus.signal_detected = sd;
    bus.sample_valid    = sv;
    bus.bank_release    = rel;
    model_step(sd, sv, rel, rst);
  endtask

  initial begin
    bit            sd_r;
    int            run_left;
    bit            sv_r;
    bit            rst_r;
    logic [NB-1:0] rel_r;

    reset               = 1'b1;
    bus.signal_detected = 1'b0;
    bus.sample_valid    = 1'b0;
    bus.bank_release    = '0;
    model_reset();

    cycle_step(0, 0, '0, 1);
    cycle_step(0, 0, '0, 0);
    #1;
    check("reset idx_final", bus.idx_final, 0);
    check("reset done_bank", bus.done_bank, 0);
    check("reset bank", bus.bank, NB - 1);
    check("reset frame_done", bus.frame_done, 0);
    check("reset mem_completed", bus.memorization_completed, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset we", bus.we, 0);

    // Short burst of three samples lands in bank 0.
    cycle_step(1, 1, '0, 0);
    repeat (3) cycle_step(1, 1, '0, 0);
    cycle_step(0, 0, '0, 0);
    cycle_step(0, 0, '0, 0);
    cycle_step(0, 0, '0, 0);
    #1;
    check("burst bank_full", bus.bank_full, 4'b0001);
    check("burst idx_final", bus.idx_final, 2);
    check("burst done_bank", bus.done_bank, 0);

    // Sample_valid toggled every other cycle; bank 1 then bank 2 fill.
    for (int i = 0; i < 24; i++) cycle_step(1, i[0], '0, 0);
    cycle_step(0, 0, 4'b1111, 0);
    cycle_step(0, 0, '0, 0);

    // Randomized bursts, stalls, releases and occasional reset.
    sd_r     = 1'b0;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        sd_r     = !sd_r;
        run_left = sd_r ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 4));
      end
      run_left--;
      sv_r  = ($urandom_range(0, 3) != 0);
      rst_r = ($urandom_range(0, 399) == 0);
      rel_r = '0;
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 24) == 0) rel_r[b] = 1'b1;
      cycle_step(sd_r, rst_r ? 1'b0 : sv_r, rel_r, rst_r);
    end

    // Fill every bank, then hammer blocked bursts until drop_count saturates.
    cycle_step(0, 0, '0, 1);
    for (int i = 0; i < 30; i++) cycle_step(1, 1, '0, 0);
    for (int i = 0; i < 600; i++) cycle_step(!i[0], 1, '0, 0);
    cycle_step(0, 0, '0, 0);
    #1;
    check("saturated drop_count", bus.drop_count, 255);
    check("all banks full", bus.bank_full, 4'b1111);

    // Release bank 0: the next burst resumes at address 0.
    cycle_step(0, 0, 4'b0001, 0);
    cycle_step(0, 0, '0, 0);
    cycle_step(1, 1, '0, 0);
    cycle_step(1, 1, '0, 0);
    #1;
    check("resume we", bus.we, 1);
    check("resume addr", bus.addr_in, 0);

    // Reset in the middle of a capture at idx 3.
    cycle_step(1, 1, '0, 0);
    cycle_step(1, 1, '0, 0);
    cycle_step(1, 0, '0, 1);
    cycle_step(1, 1, '0, 0);
    #1;
    check("post-reset state", bus.state_reg, 0);
    check("post-reset bank_full", bus.bank_full, 0);
    cycle_step(1, 1, '0, 0);
    #1;
    check("post-reset first addr", bus.addr_in, 0);
    check("post-reset first we", bus.we, 1);

    repeat (8) cycle_step(0, 0, '0, 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("write queue drained", wr_q.size(), 0);
    check("frame queue drained", fr_q.size(), 0);
    check("overflow queue drained", ov_q.size(), 0);
    check("mem_completed queue drained", mc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
